// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tts_pkg;

  typedef enum logic [1:0] {TTS_IDLE, TTS_APPLY, TTS_SAMPLE, TTS_DONE} tts_state_t;

  function automatic int tts_vec_count(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tts_settle_timer.sv
// Settle-window down-counter: load arms it, expire flags the last cycle of the window.
module tts_settle_timer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(HOLD_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = LOAD_VAL;
    else if (en && cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper/checker for an N_IN-input, 1-output f-block.
// Optional TTS_CAPTURE_EN adds obs_table, the observed truth table of the last sweep.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int N_IN        = 4,
  parameter int HOLD_CYCLES = 1,
  parameter logic [tts_vec_count(N_IN)-1:0] EXPECTED = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err,
  output logic            first_valid
`ifdef TTS_CAPTURE_EN
  ,output logic [tts_vec_count(N_IN)-1:0] obs_table
`endif
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;

  tts_state_t      state_q, state_d;
  logic [N_IN-1:0] din_q, din_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ferr_q, ferr_d;
  logic            fval_q, fval_d;
`ifdef TTS_CAPTURE_EN
  logic [tts_vec_count(N_IN)-1:0] obs_q, obs_d;
`endif

  logic timer_load, timer_en, timer_expire, mism;

  tts_settle_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (timer_en),
    .expire (timer_expire)
  );

  assign mism = (dut_out != EXPECTED[din_q]);

  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    ferr_d     = ferr_q;
    fval_d     = fval_q;
`ifdef TTS_CAPTURE_EN
    obs_d      = obs_q;
`endif
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state_q)
      TTS_IDLE, TTS_DONE: begin
        if (start) begin
          din_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_d      = '0;
          ferr_d     = '0;
          fval_d     = 1'b0;
`ifdef TTS_CAPTURE_EN
          obs_d      = '0;
`endif
          timer_load = 1'b1;
          state_d    = TTS_APPLY;
        end
      end
      TTS_APPLY: begin
        timer_en = 1'b1;
        if (timer_expire) state_d = TTS_SAMPLE;
      end
      TTS_SAMPLE: begin
        if (mism) begin
          err_d = err_q + (N_IN+1)'(1);
          if (!fval_q) begin
            ferr_d = din_q;
            fval_d = 1'b1;
          end
        end
`ifdef TTS_CAPTURE_EN
        obs_d[din_q] = dut_out;
`endif
        // pass uses err_d so a mismatch on the last vector is not lost
        if (din_q == LAST_VEC) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = TTS_DONE;
        end else begin
          din_d      = din_q + N_IN'(1);
          timer_load = 1'b1;
          state_d    = TTS_APPLY;
        end
      end
      default: state_d = TTS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TTS_IDLE;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ferr_q  <= '0;
      fval_q  <= 1'b0;
`ifdef TTS_CAPTURE_EN
      obs_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      fval_q  <= fval_d;
`ifdef TTS_CAPTURE_EN
      obs_q   <= obs_d;
`endif
    end
  end

  assign dut_in      = din_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign first_err   = ferr_q;
  assign first_valid = fval_q;
`ifdef TTS_CAPTURE_EN
  assign obs_table   = obs_q;
`endif

endmodule
